// File: rtl/sbox_pkg.sv
// Shared sizes and FSM encoding for the writable DES S-box store.
// No logic; latency not applicable.
// Backpressure not applicable; CHK is only reachable when SBOX_CHECKSUM_EN is defined.
package sbox_pkg;
   localparam int NUM_BOX     = 8;
   localparam int ENTRIES     = 64;
   localparam int DW          = 4;
   localparam int TABLE_DEPTH = NUM_BOX * ENTRIES;
   localparam int ADDR_W      = 9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CHK  = 2'd2
   } state_t;
endpackage

// File: rtl/sbox_table_loader_if.sv
// Bundle of load-stream handshake, lookup request and status signals of the S-box store.
// Pure wiring, no latency.
// Stream beat moves when s_valid & s_ready; lookup side has no backpressure.
interface sbox_table_loader_if;
   import sbox_pkg::*;

   logic          load_start;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic [2:0]    box;
   logic [1:0]    row;
   logic [3:0]    col;
   logic [DW-1:0] dout;
   logic          busy;
   logic          loaded;
   logic          err;

   modport master (
      output load_start, s_valid, s_data, box, row, col,
      input  s_ready, dout, busy, loaded, err
   );

   modport slave (
      input  load_start, s_valid, s_data, box, row, col,
      output s_ready, dout, busy, loaded, err
   );
endinterface

// File: rtl/sbox_ram.sv
// 512x4 table RAM: one synchronous write port, one registered read port.
// Read data appears one cycle after raddr_i; write lands on the clock edge.
// No backpressure; rd_en_i low forces the read register to zero instead of reading.
module sbox_ram
   import sbox_pkg::*;
(
   input  logic              clk,
   input  logic              rstn_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DW-1:0]     wdata_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DW-1:0]     rdata_o
);
   logic [DW-1:0] mem_q [TABLE_DEPTH];
   logic [DW-1:0] rdata_q;

   // Table storage: contents survive reset, validity is tracked by the loader.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Registered read; gated to zero so a partial or invalid table is never visible.
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         rdata_q <= '0;
      end else if (rd_en_i) begin
         rdata_q <= mem_q[raddr_i];
      end else begin
         rdata_q <= '0;
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/sbox_table_loader.sv
// Writable DES S-box store: loads 512 nibbles from a stream, then serves {box,row,col} lookups.
// Lookup latency 1 cycle (dout registered); load takes 512 accepted beats (+2 checksum beats).
// s_ready high in LOAD/CHK, low in IDLE; optional trailing sum check under SBOX_CHECKSUM_EN.
module sbox_table_loader
   import sbox_pkg::*;
(
   input  logic                 clk,
   input  logic                 rstn,
   sbox_table_loader_if.slave   bus
);
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              loaded_q, loaded_d;
   logic              ram_we;
   logic              rd_en;
   logic              beat;

`ifdef SBOX_CHECKSUM_EN
   logic [7:0]        sum_q, sum_d;
   logic              chk_hi_q, chk_hi_d;
   logic [DW-1:0]     chk_lo_q, chk_lo_d;
   logic              err_q, err_d;
`endif

   assign beat = bus.s_valid & bus.s_ready;

   // Next state, write strobe and counter/flag updates; defaults hold every register.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      loaded_d    = loaded_q;
      ram_we      = 1'b0;
      bus.s_ready = 1'b0;
`ifdef SBOX_CHECKSUM_EN
      sum_d       = sum_q;
      chk_hi_d    = chk_hi_q;
      chk_lo_d    = chk_lo_q;
      err_d       = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.load_start) begin
               state_d  = LOAD;
               addr_d   = '0;
               loaded_d = 1'b0;
`ifdef SBOX_CHECKSUM_EN
               sum_d    = '0;
               err_d    = 1'b0;
`endif
            end
         end
         LOAD: begin
            bus.s_ready = 1'b1;
            if (bus.s_valid) begin
               ram_we = 1'b1;
`ifdef SBOX_CHECKSUM_EN
               sum_d  = sum_q + 8'(bus.s_data);
`endif
               // Terminal address is tested before incrementing, so the counter never wraps.
               if (addr_q == ADDR_W'(TABLE_DEPTH - 1)) begin
`ifdef SBOX_CHECKSUM_EN
                  state_d  = CHK;
                  chk_hi_d = 1'b0;
`else
                  state_d  = IDLE;
                  loaded_d = 1'b1;
`endif
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
`ifdef SBOX_CHECKSUM_EN
         CHK: begin
            bus.s_ready = 1'b1;
            if (bus.s_valid) begin
               if (!chk_hi_q) begin
                  chk_lo_d = bus.s_data;
                  chk_hi_d = 1'b1;
               end else begin
                  state_d = IDLE;
                  if ({bus.s_data, chk_lo_q} == sum_q) begin
                     loaded_d = 1'b1;
                  end else begin
                     loaded_d = 1'b0;
                     err_d    = 1'b1;
                  end
               end
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM, address counter and loaded flag.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         loaded_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         loaded_q <= loaded_d;
      end
   end

`ifdef SBOX_CHECKSUM_EN
   // Running sum of table nibbles plus the captured expected-sum low nibble.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sum_q    <= '0;
         chk_hi_q <= 1'b0;
         chk_lo_q <= '0;
         err_q    <= 1'b0;
      end else begin
         sum_q    <= sum_d;
         chk_hi_q <= chk_hi_d;
         chk_lo_q <= chk_lo_d;
         err_q    <= err_d;
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   // Reads only while a complete table is present and no load is running.
   assign rd_en      = (state_q == IDLE) && loaded_q;
   assign bus.busy   = (state_q != IDLE);
   assign bus.loaded = loaded_q;

   sbox_ram u_ram (
      .clk     (clk),
      .rstn_i  (rstn),
      .we_i    (ram_we),
      .waddr_i (addr_q),
      .wdata_i (bus.s_data),
      .rd_en_i (rd_en),
      .raddr_i ({bus.box, bus.row, bus.col}),
      .rdata_o (bus.dout)
   );

   logic unused_beat;
   assign unused_beat = beat;
endmodule
